instruction_sequencer: RTL and testbench
========================================

Name: instruction_sequencer

Overview:
- Multi-cycle controller that drives the single-instruction execute datapath.
- Owns the program counter and fetches from instruction memory over a req/ready handshake.
- Holds the fetched word stable and issues a one-cycle execute strobe so the datapath commits its register write.
- Handles EBREAK halt, fetch timeout, misaligned branch target, and a retired-instruction counter.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- FETCH_TIMEOUT, 15, FETCH cycles without imem_ready before FAULT (range 1..255).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin execution from IDLE; ignored in other states.
- imem_req  out  1  fetch request; high in every FETCH cycle.
- imem_addr  out  XLEN  fetch address; equals pc.
- imem_ready  in  1  fetch completes in this cycle; imem_rdata is valid. Ignored outside FETCH.
- imem_rdata  in  XLEN  fetched instruction word.
- instruction  out  XLEN  registered instruction to the datapath; changes only on a fetch completion.
- exec_en  out  1  one-cycle strobe; the datapath commits on the clk edge that ends this cycle.
- branch_taken  in  1  from datapath, sampled in EXEC; selects branch_target as next pc.
- branch_target  in  XLEN  from datapath, sampled in EXEC.
- pc  out  XLEN  current program counter.
- retired  out  32  count of executed non-EBREAK instructions; wraps modulo 2^32.
- halted  out  1  sticky; EBREAK reached.
- fault  out  1  sticky; fetch timeout or misaligned branch target.

Behaviour:
- Reset values (rst high at an edge; overrides every other input including start):
  - state=IDLE, pc=RESET_PC, instruction=32'h0000_0013 (NOP), retired=0, wait counter=0.
  - halted=0, fault=0, exec_en=0, imem_req=0.
  - Reset mid-FETCH or mid-EXEC abandons the operation; no commit, no pc update.
- States: IDLE, FETCH, EXEC, HALT, FAULT. Outputs are decoded from state only (Moore): imem_req=1 only in FETCH, exec_en=1 only in EXEC with a non-EBREAK instruction.
- IDLE: start=1 -> FETCH next cycle.
- FETCH:
  - imem_ready=1 -> instruction<=imem_rdata, wait counter<=0, next state EXEC.
  - Otherwise wait counter increments. When it reaches FETCH_TIMEOUT (counter==FETCH_TIMEOUT-1 with ready still low) -> FAULT.
  - imem_ready and timeout in the same cycle: ready wins.
- EXEC (always exactly one cycle):
  - instruction==32'h0010_0073 (EBREAK): exec_en=0, pc unchanged, retired unchanged -> HALT.
  - Otherwise exec_en=1 and retired<=retired+1.
  - If branch_taken=1 and branch_target[1:0]!=0: pc unchanged, next state FAULT. The datapath still commits that instruction's write.
  - Else pc<=branch_taken ? branch_target : pc+4, next state FETCH. pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0).
- HALT / FAULT: terminal. All outputs hold, imem_req=0, start ignored; exit only via rst.
- Latency:
  - With imem_ready tied high: 2 cycles per instruction (FETCH, EXEC).
  - Each stall cycle adds 1.
  - start to first exec_en: 2 cycles minimum.
- instruction is stable from fetch completion through the end of EXEC. The datapath never sees a changing word during exec_en.

Decomposition:
- Shared include (alongside the existing test utilities):
  - state encoding constants.
  - NOP = 32'h0000_0013, EBREAK = 32'h0010_0073.
  - OPCODE_OP_IMM = 7'b0010011.
- One sub-module: sequencer_fetch_timer. An 8-bit wait counter with clear and enable inputs and an expired output compared against FETCH_TIMEOUT.
- Top level wires instruction_sequencer to single_instruction; the sequencer has no knowledge of the register file.

Test Plan:
- Reset then idle: rst=1 for 1 edge, start=0 for 5 cycles -> pc=0, instruction=32'h13, imem_req=0, exec_en never high.
- Two ADDIs, ready tied high:
  - Setup: mem[0]={12'd12,5'd0,3'b000,5'd5,7'b0010011}, mem[4]={12'd20,...}, start pulse.
  - Required: exec_en high on cycles 2 and 4; x5=12 after the first strobe and 20 after the second; pc=8; retired=2.
- Fetch stall: imem_ready low for 3 cycles at pc=0 -> imem_req held 4 cycles, instruction unchanged until the ready cycle, one exec_en.
- Timeout: FETCH_TIMEOUT=4, imem_ready never high -> fault=1 after 4 FETCH cycles, imem_req=0 thereafter, start ignored.
- EBREAK: mem[4]=32'h0010_0073 -> halted=1, pc=4, retired=1, exec_en not asserted for EBREAK.
- Branch, wrap and reset:
  - branch_taken=1, target=32'h0000_0040 -> next imem_addr=32'h40.
  - Target 32'h42 -> fault=1, pc unchanged.
  - RESET_PC=32'hFFFF_FFFC with ADDI -> pc wraps to 0.
  - rst during EXEC -> no retire, pc=RESET_PC.

Source files
------------

// File: rtl/instruction_sequencer_pkg.sv
// instruction_sequencer_pkg: shared state encoding and instruction constants
package instruction_sequencer_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT, S_FAULT} state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
endpackage

// File: rtl/instruction_sequencer_fetch_timer.sv
// sequencer_fetch_timer: counts stalled fetch cycles and flags the timeout
module sequencer_fetch_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt;
  assign expired = cnt == 8'(TIMEOUT - 1);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: multi-cycle fetch/execute controller with halt and fault handling
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instruction,
  output logic            exec_en,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     retired,
  output logic            halted,
  output logic            fault
);
  state_t state, state_n;
  logic expired, misaligned, is_ebreak;
  assign is_ebreak = instruction == XLEN'(EBREAK);
  assign misaligned = branch_taken && (branch_target[1:0] != 2'b00);
  assign imem_req = state == S_FETCH;
  assign imem_addr = pc;
  assign exec_en = state == S_EXEC && !is_ebreak;
  assign halted = state == S_HALT;
  assign fault = state == S_FAULT;
  sequencer_fetch_timer #(.TIMEOUT(FETCH_TIMEOUT)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(!imem_req || imem_ready),
    .en(imem_req && !imem_ready),
    .expired(expired)
  );
  always_comb begin
    state_n = state;
    state_n = state == S_IDLE  ? (start ? S_FETCH : S_IDLE)
            : state == S_FETCH ? (imem_ready ? S_EXEC : expired ? S_FAULT : S_FETCH)
            : state == S_EXEC  ? (is_ebreak ? S_HALT : misaligned ? S_FAULT : S_FETCH)
            : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc <= RESET_PC;
      instruction <= XLEN'(NOP);
      retired <= '0;
    end else begin
      state <= state_n;
      if (imem_req && imem_ready) instruction <= imem_rdata;
      if (exec_en) retired <= retired + 32'd1;
      if (exec_en && !misaligned) pc <= branch_taken ? branch_target : pc + XLEN'(4);
    end
  end
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: directed self-checking bench for instruction_sequencer
module tb_instruction_sequencer;
  logic clk = 0, rst = 1, start = 0, rdy = 1, bt = 0;
  logic [31:0] btgt = '0;
  logic [31:0] mem [32];
  logic        req, en, halted, fault;
  logic [31:0] addr, rdata, instr, pc, retired;
  logic        w_req, w_en, w_halted, w_fault;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_retired;
  int vectors = 0, miscompares = 0;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EBRK = 32'h0010_0073;
  localparam logic [31:0] ADDI12 = {12'd12, 5'd0, 3'b000, 5'd5, 7'b0010011};
  localparam logic [31:0] ADDI20 = {12'd20, 5'd0, 3'b000, 5'd5, 7'b0010011};
  always #5 clk = ~clk;
  assign rdata = mem[addr[6:2]];
  assign w_rdata = mem[w_addr[6:2]];
  instruction_sequencer #(.XLEN(32), .RESET_PC(32'h0), .FETCH_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_req(req), .imem_addr(addr),
    .imem_ready(rdy), .imem_rdata(rdata), .instruction(instr), .exec_en(en),
    .branch_taken(bt), .branch_target(btgt), .pc(pc), .retired(retired),
    .halted(halted), .fault(fault)
  );
  instruction_sequencer #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .FETCH_TIMEOUT(15)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(rdy), .imem_rdata(w_rdata), .instruction(w_instr), .exec_en(w_en),
    .branch_taken(bt), .branch_target(btgt), .pc(w_pc), .retired(w_retired),
    .halted(w_halted), .fault(w_fault)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = NOP;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      chk("idle_req", 32'(req), 0);
      chk("idle_en", 32'(en), 0);
      tick();
    end
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, NOP);
    chk("rst_retired", retired, 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
    mem[0] = ADDI12; mem[1] = ADDI20; mem[2] = EBRK; mem[31] = ADDI12;
    start = 1;
    tick();
    start = 0;
    chk("c1_req", 32'(req), 1);
    chk("c1_addr", addr, 0);
    chk("c1_en", 32'(en), 0);
    tick();
    chk("c2_en", 32'(en), 1);
    chk("c2_instr", instr, ADDI12);
    chk("c2_pc", pc, 0);
    tick();
    chk("c3_pc", pc, 4);
    chk("c3_retired", retired, 1);
    chk("c3_en", 32'(en), 0);
    chk("wrap_pc", w_pc, 0);
    chk("wrap_retired", w_retired, 1);
    tick();
    chk("c4_en", 32'(en), 1);
    chk("c4_instr", instr, ADDI20);
    tick();
    chk("c5_pc", pc, 8);
    chk("c5_retired", retired, 2);
    tick();
    chk("ebrk_en", 32'(en), 0);
    chk("ebrk_instr", instr, EBRK);
    tick();
    chk("halt_halted", 32'(halted), 1);
    chk("halt_pc", pc, 8);
    chk("halt_retired", retired, 2);
    chk("halt_req", 32'(req), 0);
    start = 1;
    tick();
    start = 0;
    chk("halt_sticky", 32'(halted), 1);
    chk("halt_start_req", 32'(req), 0);
    do_reset();
    mem[0] = ADDI12; mem[1] = EBRK;
    rdy = 0;
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", 32'(req), 1);
      chk("stall_instr", instr, NOP);
      chk("stall_en", 32'(en), 0);
      tick();
    end
    rdy = 1;
    chk("stall_ready_req", 32'(req), 1);
    tick();
    chk("stall_fault", 32'(fault), 0);
    chk("stall_en_exec", 32'(en), 1);
    chk("stall_instr_exec", instr, ADDI12);
    tick();
    chk("eb_pc_fetch", pc, 4);
    tick();
    chk("eb_en", 32'(en), 0);
    tick();
    chk("eb_halted", 32'(halted), 1);
    chk("eb_pc", pc, 4);
    chk("eb_retired", retired, 1);
    do_reset();
    rdy = 0;
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 4; i++) begin
      chk("to_req", 32'(req), 1);
      chk("to_fault_early", 32'(fault), 0);
      tick();
    end
    chk("to_fault", 32'(fault), 1);
    chk("to_req_off", 32'(req), 0);
    start = 1;
    tick();
    start = 0;
    chk("to_fault_sticky", 32'(fault), 1);
    chk("to_req_stay", 32'(req), 0);
    chk("to_pc", pc, 0);
    rdy = 1;
    do_reset();
    mem[0] = ADDI12; mem[16] = ADDI20;
    start = 1;
    tick();
    start = 0;
    tick();
    bt = 1; btgt = 32'h40;
    chk("br_en", 32'(en), 1);
    tick();
    bt = 0;
    chk("br_pc", pc, 32'h40);
    chk("br_addr", addr, 32'h40);
    chk("br_req", 32'(req), 1);
    chk("br_retired", retired, 1);
    tick();
    chk("br2_instr", instr, ADDI20);
    bt = 1; btgt = 32'h42;
    tick();
    bt = 0;
    chk("mis_fault", 32'(fault), 1);
    chk("mis_pc", pc, 32'h40);
    chk("mis_retired", retired, 2);
    do_reset();
    start = 1;
    tick();
    start = 0;
    tick();
    chk("rx_en", 32'(en), 1);
    do_reset();
    chk("rx_pc", pc, 0);
    chk("rx_retired", retired, 0);
    chk("rx_en_off", 32'(en), 0);
    chk("rx_instr", instr, NOP);
    chk("rx_fault", 32'(fault), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
